// File: rtl/delay_tap_scheduler.sv
// Echo/delay sequencer: writes x(n) to the circular buffer, fetches up to two taps, MACs them on one multiplier.
// Latency 4 cycles (one tap) or 6 (two taps); no backpressure, samples arriving while busy are dropped and flagged on overrun_o.
module delay_tap_scheduler #(
    parameter int ADDR_W   = 12,
    parameter int GAIN_MAX = 20
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                sample_valid_i,
    input  logic [15:0]         sample_in_i,
    input  logic                bypass_i,
    input  logic [4:0]          delay_gain_i,
    input  logic [ADDR_W-1:0]   delay_time_i,
    input  logic [1:0]          delay_repeat_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_we_o,
    output logic [15:0]         mem_wdata_o,
    input  logic [15:0]         mem_rdata_i,
    output logic [15:0]         out_o,
    output logic                out_valid_o,
    output logic                busy_o,
    output logic                overrun_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD1,
        S_MAC1,
        S_RD2,
        S_MAC2,
        S_OUT
    } state_t;

    localparam logic [4:0]        GMAX     = 5'(GAIN_MAX);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] FILL_MAX = '1;

    state_t                state_q;
    logic [15:0]           x_q;
    logic                  byp_q;
    logic [4:0]            g_q;
    logic [ADDR_W-1:0]     d_q;
    logic                  two_q;
    logic [ADDR_W-1:0]     wr_ptr_q;
    logic [ADDR_W-1:0]     fill_q;
    logic signed [23:0]    acc_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic                  mem_we_q;
    logic [15:0]           mem_wdata_q;
    logic [15:0]           out_q;
    logic                  out_valid_q;
    logic                  overrun_q;

    logic [4:0]            g_d;
    logic [ADDR_W-1:0]     d_d;
    logic [ADDR_W-1:0]     rd1_addr_d;
    logic [ADDR_W-1:0]     rd2_addr_d;
    logic [10:0]           coef_d;
    logic signed [26:0]    prod_d;
    logic signed [23:0]    term_d;
    logic                  tap_ok_d;
    logic signed [23:0]    acc_d;
    logic [15:0]           sat_d;
    logic [15:0]           res_d;

    always_comb begin
        g_d        = (delay_gain_i > GMAX) ? GMAX : delay_gain_i;
        d_d        = (delay_time_i == '0) ? PTR_ONE : delay_time_i;
        rd1_addr_d = wr_ptr_q - d_q;
        rd2_addr_d = wr_ptr_q - {d_q[ADDR_W-2:0], 1'b0};
        // One shared multiplier: the coefficient is chosen by which MAC slot we are in.
        coef_d     = (state_q == S_MAC2) ? 11'(g_q) * 11'd38 : 11'(g_q) * 11'd51;
        prod_d     = {{11{mem_rdata_i[15]}}, mem_rdata_i} * {16'd0, coef_d};
        term_d     = 24'(prod_d >>> 10);
        // A tap reaching back past the oldest written sample contributes nothing.
        tap_ok_d   = (state_q == S_MAC2) ? ({1'b0, fill_q} >= {d_q, 1'b0})
                                         : (fill_q >= d_q);
        acc_d      = acc_q + (tap_ok_d ? term_d : 24'sd0);
        if (acc_d > 24'sd32767) begin
            sat_d = 16'h7fff;
        end else if (acc_d < -24'sd32768) begin
            sat_d = 16'h8000;
        end else begin
            sat_d = acc_d[15:0];
        end
        res_d      = byp_q ? x_q : sat_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            byp_q       <= 1'b0;
            g_q         <= '0;
            d_q         <= PTR_ONE;
            two_q       <= 1'b0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            acc_q       <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            mem_we_q    <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= sample_valid_i && (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (sample_valid_i) begin
                        x_q         <= sample_in_i;
                        byp_q       <= bypass_i;
                        g_q         <= g_d;
                        d_q         <= d_d;
                        two_q       <= (delay_repeat_i == 2'd2);
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= wr_ptr_q;
                        mem_wdata_q <= sample_in_i;
                        state_q     <= S_WR;
                    end
                end
                S_WR: begin
                    acc_q      <= {{8{x_q[15]}}, x_q};
                    mem_addr_q <= rd1_addr_d;
                    state_q    <= S_RD1;
                end
                S_RD1: begin
                    state_q <= S_MAC1;
                end
                S_MAC1: begin
                    acc_q <= acc_d;
                    if (two_q) begin
                        mem_addr_q <= rd2_addr_d;
                        state_q    <= S_RD2;
                    end else begin
                        out_q       <= res_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_OUT;
                    end
                end
                S_RD2: begin
                    state_q <= S_MAC2;
                end
                S_MAC2: begin
                    acc_q       <= acc_d;
                    out_q       <= res_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    wr_ptr_q <= wr_ptr_q + PTR_ONE;
                    if (fill_q != FILL_MAX) begin
                        fill_q <= fill_q + PTR_ONE;
                    end
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign mem_we_o    = mem_we_q;
    assign mem_wdata_o = mem_wdata_q;
    assign out_o       = out_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = (state_q != S_IDLE);
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_delay_tap_scheduler.sv
// Directed bench for delay_tap_scheduler with a 16-entry buffer and a synchronous single-port RAM model.
module tb_delay_tap_scheduler;

    logic               clk;
    logic               rst_n;
    logic               sample_valid;
    logic signed [15:0] sample_in;
    logic               bypass;
    logic [4:0]         delay_gain;
    logic [3:0]         delay_time;
    logic [1:0]         delay_repeat;
    logic [3:0]         mem_addr;
    logic               mem_we;
    logic signed [15:0] mem_wdata;
    logic [15:0]        mem_rdata;
    logic signed [15:0] out_s;
    logic               out_valid;
    logic               busy;
    logic               overrun;

    logic [15:0]        ram [16];
    int                 n_cmp = 0;
    int                 n_err = 0;

    delay_tap_scheduler #(.ADDR_W(4), .GAIN_MAX(20)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .sample_valid_i (sample_valid),
        .sample_in_i    (sample_in),
        .bypass_i       (bypass),
        .delay_gain_i   (delay_gain),
        .delay_time_i   (delay_time),
        .delay_repeat_i (delay_repeat),
        .mem_addr_o     (mem_addr),
        .mem_we_o       (mem_we),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata),
        .out_o          (out_s),
        .out_valid_o    (out_valid),
        .busy_o         (busy),
        .overrun_o      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Presents one sample for exactly one cycle; returns #1 after the sampling edge.
    task automatic drive_sample(input logic signed [15:0] x, input logic byp, input logic [4:0] g,
                                input logic [3:0] d, input logic [1:0] rep);
        @(negedge clk);
        sample_in    = x;
        bypass       = byp;
        delay_gain   = g;
        delay_time   = d;
        delay_repeat = rep;
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic run_sample(input string tag, input logic signed [15:0] x, input logic byp,
                              input logic [4:0] g, input logic [3:0] d, input logic [1:0] rep,
                              input int exp_out, input logic [3:0] wp);
        int         cnt;
        int         dd;
        logic [3:0] a1;
        logic [3:0] a2;
        dd = (d == 0) ? 1 : int'(d);
        a1 = 4'(int'(wp) - dd);
        a2 = 4'(int'(wp) - 2 * dd);
        drive_sample(x, byp, g, d, rep);
        cnt = 1;
        check({tag, ".we"}, mem_we, 1);
        check({tag, ".wr_addr"}, mem_addr, wp);
        check({tag, ".wdata"}, mem_wdata, x);
        @(posedge clk);
        #1;
        cnt = 2;
        check({tag, ".rd1_addr"}, mem_addr, a1);
        check({tag, ".we_rd"}, mem_we, 0);
        while (out_valid !== 1'b1 && cnt < 12) begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt == 4 && rep == 2'd2) check({tag, ".rd2_addr"}, mem_addr, a2);
        end
        check({tag, ".latency"}, cnt, (rep == 2'd2) ? 6 : 4);
        check({tag, ".out"}, out_s, exp_out);
        @(posedge clk);
        #1;
        check({tag, ".vld_drop"}, out_valid, 0);
        check({tag, ".out_hold"}, out_s, exp_out);
        check({tag, ".idle"}, busy, 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        bypass       = 1'b0;
        delay_gain   = '0;
        delay_time   = '0;
        delay_repeat = '0;
        for (int i = 0; i < 16; i++) ram[i] = 16'd0;

        do_reset();
        check("rst.out", out_s, 0);
        check("rst.out_valid", out_valid, 0);
        check("rst.overrun", overrun, 0);
        check("rst.mem_we", mem_we, 0);
        check("rst.mem_addr", mem_addr, 0);
        check("rst.mem_wdata", mem_wdata, 0);
        check("rst.busy", busy, 0);

        // One tap, D=3: first three samples see an unfilled buffer.
        for (int i = 0; i < 8; i++)
            run_sample("tap1", 16'sd1000, 1'b0, 5'd20, 4'd3, 2'd1, (i < 3) ? 1000 : 1996, 4'(i));

        // Two taps, D=2: tap1 from the 3rd sample, tap2 from the 5th.
        do_reset();
        run_sample("tap2.a", 16'sd10000, 1'b0, 5'd20, 4'd2, 2'd2, 10000, 4'd0);
        run_sample("tap2.b", 16'sd10000, 1'b0, 5'd20, 4'd2, 2'd2, 10000, 4'd1);
        run_sample("tap2.c", 16'sd10000, 1'b0, 5'd20, 4'd2, 2'd2, 19960, 4'd2);
        run_sample("tap2.d", 16'sd10000, 1'b0, 5'd20, 4'd2, 2'd2, 19960, 4'd3);
        run_sample("tap2.e", 16'sd10000, 1'b0, 5'd20, 4'd2, 2'd2, 27381, 4'd4);
        for (int i = 5; i < 10; i++)
            run_sample("satpos", 16'sd20000, 1'b0, 5'd20, 4'd2, 2'd2, 32767, 4'(i));

        // Negative saturation, then G=0 leaves the sample untouched.
        do_reset();
        run_sample("satneg.a", -16'sd30000, 1'b0, 5'd20, 4'd1, 2'd2, -30000, 4'd0);
        for (int i = 1; i < 5; i++)
            run_sample("satneg", -16'sd30000, 1'b0, 5'd20, 4'd1, 2'd2, -32768, 4'(i));
        run_sample("gain0", -16'sd30000, 1'b0, 5'd0, 4'd1, 2'd2, -30000, 4'd5);

        // Bypass still writes history; the following echo reads it.
        do_reset();
        run_sample("byp.a", 16'sd5000, 1'b1, 5'd20, 4'd1, 2'd2, 5000, 4'd0);
        run_sample("byp.b", -16'sd7, 1'b1, 5'd20, 4'd1, 2'd2, -7, 4'd1);
        run_sample("byp.c", 16'sd123, 1'b1, 5'd20, 4'd1, 2'd2, 123, 4'd2);
        run_sample("byp.hist", 16'sd1000, 1'b0, 5'd20, 4'd1, 2'd1, 1122, 4'd3);

        // Wrap: 20 samples of i*100 with D=5 in a 16-deep buffer.
        do_reset();
        for (int i = 0; i < 20; i++)
            run_sample("wrap", 16'(i * 100), 1'b0, 5'd20, 4'd5, 2'd1,
                       (i < 5) ? i * 100 : i * 100 + ((i - 5) * 102000) / 1024, 4'(i));
        // Gain 31 clamps to 20, D=0 acts as 1, repeat=3 acts as one tap.
        run_sample("clamp", 16'sd100, 1'b0, 5'd31, 4'd0, 2'd3, 1992, 4'd4);

        // Second strobe two cycles after the first is dropped.
        do_reset();
        drive_sample(16'sd1000, 1'b0, 5'd20, 4'd1, 2'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        sample_in    = -16'sd5000;
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        check("ovr.pulse", overrun, 1);
        check("ovr.no_vld_yet", out_valid, 0);
        @(posedge clk);
        #1;
        check("ovr.pulse_end", overrun, 0);
        check("ovr.first_vld", out_valid, 1);
        check("ovr.first_out", out_s, 1000);
        @(posedge clk);
        #1;
        run_sample("ovr.next", 16'sd500, 1'b0, 5'd20, 4'd1, 2'd1, 1496, 4'd1);

        // Reset during MAC1 aborts the sample.
        drive_sample(16'sd700, 1'b0, 5'd20, 4'd1, 2'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("abort.busy_mac", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort.no_vld", out_valid, 0);
        check("abort.idle", busy, 0);
        check("abort.addr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("abort.quiet", out_valid, 0);
        end
        run_sample("abort.next", 16'sd300, 1'b0, 5'd20, 4'd1, 2'd1, 300, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
